// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding and word geometry.
package program_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN   = 3'd0;
    localparam state_t ST_DATA  = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: a wrapping byte counter plus a right-shifting word register.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [31:0] word_nx,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;

    // Newest byte enters at the top, so after four shifts the first byte sits in bits 7:0.
    assign word_nx    = {din, shift_q[31:8]};
    assign word_valid = en && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = shift_q;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            byte_cnt <= 2'd0;
            shift_q  <= 32'd0;
        end else if (en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= word_nx;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory, holding the core in reset meanwhile.
//   state | meaning
//   LEN   | collecting the 4-byte word count N
//   DATA  | collecting the 4 bytes of the next instruction word
//   WRITE | one-cycle instruction-memory write of the assembled word
//   DONE  | image complete, core released; start reloads
//   ERR   | N exceeded capacity; only rstn leaves
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    state_t           state, state_nx;
    logic [31:0]      n_words;
    logic [IDX_W-1:0] word_idx;
    logic             cpu_rstn_q;
    logic             accept;
    logic             clr;
    logic             last_word;
    logic [31:0]      word_cur;
    logic [31:0]      word_nx;
    logic             word_valid;

    assign rx_ready  = (state == ST_LEN) || (state == ST_DATA);
    assign accept    = rx_valid && rx_ready;
    assign clr       = (state == ST_DONE) && start;
    assign last_word = (32'(word_idx) + 32'd1) == n_words;

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .en         (accept),
        .din        (rx_data),
        .word       (word_cur),
        .word_nx    (word_nx),
        .word_valid (word_valid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_LEN: begin
                if (word_valid) begin
                    if (word_nx == 32'd0)
                        state_nx = ST_DONE;
                    else if (word_nx > 32'(MAX_WORDS))
                        state_nx = ST_ERR;
                    else
                        state_nx = ST_DATA;
                end
            end
            ST_DATA:  if (word_valid) state_nx = ST_WRITE;
            ST_WRITE: state_nx = last_word ? ST_DONE : ST_DATA;
            ST_DONE:  if (start) state_nx = ST_LEN;
            ST_ERR:   state_nx = ST_ERR;
            default:  state_nx = ST_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_LEN;
            n_words    <= 32'd0;
            word_idx   <= '0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state      <= state_nx;
            // Registered so the core leaves reset on the very cycle DONE is entered.
            cpu_rstn_q <= (state_nx == ST_DONE);
            if (clr) begin
                n_words  <= 32'd0;
                word_idx <= '0;
            end else begin
                if (state == ST_LEN && word_valid)
                    n_words <= word_nx;
                if (state == ST_WRITE)
                    word_idx <= word_idx + 1'b1;
            end
        end
    end

    assign imem_we   = (state == ST_WRITE);
    assign imem_addr = imem_we ? ADDR_W'({word_idx, 2'b00}) : '0;
    assign imem_din  = imem_we ? word_cur : 32'd0;
    assign cpu_rstn  = cpu_rstn_q;
    assign busy      = (state == ST_LEN) || (state == ST_DATA) || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: scenario tasks with hand-computed writes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        start = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        cpu_rstn;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    int          wr_cnt = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          idle_nonzero = 0;

    program_loader #(.MAX_WORDS(4096), .ADDR_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .start     (start),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .cpu_rstn  (cpu_rstn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_din;
            end
            wr_cnt++;
        end else if (imem_addr !== 32'd0 || imem_din !== 32'd0) begin
            idle_nonzero++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; rx_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_byte_timeout got rx_ready=%b exp=1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_din} !== 65'd0) begin
            failures++;
            $display("FAIL reset_imem got we=%b addr=%h din=%h exp=0/0/0", imem_we, imem_addr, imem_din);
        end
        checks++;
        if ({cpu_rstn, done, err, busy, rx_ready} !== 5'b00011) begin
            failures++;
            $display("FAIL reset_status got cpu_rstn,done,err,busy,rx_ready=%b exp=00011",
                     {cpu_rstn, done, err, busy, rx_ready});
        end
    endtask

    task automatic test_two_words();
        int base;
        do_reset();
        base = wr_cnt;
        send_word(32'd2);
        send_word(32'hfe010113);
        send_word(32'h00112e23);
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 32'd4 || imem_din !== 32'h00112e23) begin
            failures++;
            $display("FAIL two_words_latency got we=%b addr=%h din=%h exp=1/4/00112e23", imem_we, imem_addr, imem_din);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_rstn !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL two_words_done got done=%b cpu_rstn=%b busy=%b exp=1/1/0", done, cpu_rstn, busy);
        end
        checks++;
        if (wr_cnt - base !== 2 || wr_addr[base] !== 32'd0 || wr_data[base] !== 32'hfe010113
            || wr_addr[base+1] !== 32'd4 || wr_data[base+1] !== 32'h00112e23) begin
            failures++;
            $display("FAIL two_words_log got n=%0d (%h,%h) (%h,%h) exp=2 (0,fe010113) (4,00112e23)",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
    endtask

    task automatic test_zero_len();
        int base;
        do_reset();
        base = wr_cnt;
        send_word(32'd0);
        @(negedge clk);
        checks++;
        if (cpu_rstn !== 1'b1 || done !== 1'b1 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done got cpu_rstn=%b done=%b rx_ready=%b exp=1/1/0", cpu_rstn, done, rx_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 0) begin
            failures++;
            $display("FAIL zero_len_nowrite got writes=%0d exp=0", wr_cnt - base);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(32'd4097);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || rx_ready !== 1'b0 || cpu_rstn !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overflow_err got err=%b rx_ready=%b cpu_rstn=%b busy=%b exp=1/0/0/0",
                     err, rx_ready, cpu_rstn, busy);
        end
        pulse_start();
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || cpu_rstn !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overflow_start_ignored got err=%b cpu_rstn=%b busy=%b exp=1/0/0", err, cpu_rstn, busy);
        end
        do_reset();
        send_word(32'd4096);
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL max_words_accepted got err=%b rx_ready=%b busy=%b exp=0/1/1", err, rx_ready, busy);
        end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        base = wr_cnt;
        send_word(32'd1);
        send_word(32'h12345678);
        @(negedge clk);
        do_reset();
        send_word(32'd1);
        send_byte(8'h78); repeat (5) @(negedge clk);
        send_byte(8'h56); repeat (5) @(negedge clk);
        send_byte(8'h34); repeat (5) @(negedge clk);
        send_byte(8'h12);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 2 || wr_addr[base] !== 32'd0 || wr_data[base] !== 32'h12345678
            || wr_addr[base+1] !== 32'd0 || wr_data[base+1] !== 32'h12345678) begin
            failures++;
            $display("FAIL gaps_write got n=%0d gapless=(%h,%h) gapped=(%h,%h) exp=2 (0,12345678) twice",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if (done !== 1'b1 || cpu_rstn !== 1'b1) begin
            failures++;
            $display("FAIL gaps_done got done=%b cpu_rstn=%b exp=1/1", done, cpu_rstn);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = wr_cnt;
        send_word(32'd3);
        send_word(32'hddccbbaa);
        send_byte(8'hee);
        send_byte(8'hff);
        do_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1 || {imem_we, imem_addr, imem_din, cpu_rstn, done, err} !== 68'd0) begin
            failures++;
            $display("FAIL reset_mid_len got busy=%b rx_ready=%b we=%b cpu_rstn=%b done=%b err=%b exp=1/1/0/0/0/0",
                     busy, rx_ready, imem_we, cpu_rstn, done, err);
        end
        send_word(32'd1);
        send_word(32'h44332211);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 2 || wr_addr[base] !== 32'd0 || wr_data[base] !== 32'hddccbbaa
            || wr_addr[base+1] !== 32'd0 || wr_data[base+1] !== 32'h44332211) begin
            failures++;
            $display("FAIL reset_mid_reload got n=%0d (%h,%h) (%h,%h) exp=2 (0,ddccbbaa) (0,44332211)",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_done got done=%b exp=1", done);
        end
    endtask

    task automatic test_restart();
        int base;
        // Entered from the DONE state left by the previous scenario.
        base = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rstn !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_cpu_rstn got cpu_rstn=%b done=%b busy=%b rx_ready=%b exp=0/0/1/1",
                     cpu_rstn, done, busy, rx_ready);
        end
        pulse_start();
        send_word(32'd2);
        send_word(32'h04030201);
        send_word(32'h08070605);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 2 || wr_addr[base] !== 32'd0 || wr_data[base] !== 32'h04030201
            || wr_addr[base+1] !== 32'd4 || wr_data[base+1] !== 32'h08070605) begin
            failures++;
            $display("FAIL restart_writes got n=%0d (%h,%h) (%h,%h) exp=2 (0,04030201) (4,08070605)",
                     wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if (done !== 1'b1 || cpu_rstn !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got done=%b cpu_rstn=%b exp=1/1", done, cpu_rstn);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_restart();
        checks++;
        if (idle_nonzero !== 0) begin
            failures++;
            $display("FAIL idle_bus_zero got nonzero_cycles=%0d exp=0", idle_nonzero);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4096, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning imem_addr width in bits.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_valid  input  1  byte-stream data valid (from the UART receiver).
REQ-006 SHALL have port rx_data  input  8  byte-stream payload.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port start  input  1  single-cycle pulse requesting a reload.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port imem_addr  output  ADDR_W  byte address of the write, word-aligned.
REQ-011 SHALL have port imem_din  output  32  instruction word to write.
REQ-012 SHALL have port cpu_rstn  output  1  active-low core reset; low while loading.
REQ-013 SHALL have port busy  output  1  high in LEN, DATA or WRITE.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port err  output  1  high in ERR.

Function
REQ-016 SHALL implement the states LEN, DATA, WRITE, DONE and ERR.
REQ-017 SHALL accept a byte only when rx_valid and rx_ready are both high.
REQ-018 SHALL drive rx_ready high in LEN and DATA and low in all other states.
REQ-019 SHALL assemble bytes little-endian: the first byte of a group fills bits 7:0 and the fourth fills bits 31:24.
REQ-020 SHALL, in LEN, take the first 4 accepted bytes as the 32-bit word count N.
REQ-021 SHALL, on the 4th LEN byte, go to DONE if N=0, to ERR if N>MAX_WORDS, and to DATA otherwise.
REQ-022 SHALL, in DATA, go to WRITE on each 4th accepted byte.
REQ-023 SHALL, in WRITE, assert imem_we for exactly one cycle with imem_addr = word_idx*4 and imem_din = the assembled word.
REQ-024 SHALL, after WRITE, increment word_idx and go to DONE if word_idx+1=N, otherwise return to DATA.
REQ-025 SHALL start each write one cycle after its 4th byte is accepted (write latency 1).
REQ-026 SHALL sustain a throughput of one byte per cycle except for the single WRITE stall cycle.
REQ-027 SHALL, when rx_valid gaps occur, hold all partial-word state unchanged.
REQ-028 SHALL drive imem_we low in every state except WRITE.
REQ-029 SHALL drive imem_addr and imem_din to 0 whenever imem_we is low.
REQ-030 SHALL drive cpu_rstn high only in DONE, registered, first high on the cycle DONE is entered.
REQ-031 SHALL hold cpu_rstn low in ERR.
REQ-032 SHALL, on start in DONE, clear word_idx, the byte counter and N, drive cpu_rstn low and go to LEN.
REQ-033 SHALL ignore start in LEN, DATA and WRITE.
REQ-034 SHALL, in ERR, leave only through rstn and ignore start.
REQ-035 SHALL keep the byte counter 2 bits wide (wraps 3->0 per word).
REQ-036 SHALL size word_idx to clog2(MAX_WORDS)+1 bits so that the count N=MAX_WORDS is representable.

Reset
REQ-037 SHALL, when rstn is low at a clock edge, enter LEN.
REQ-038 SHALL clear N, word_idx and the byte counter on reset.
REQ-039 SHALL reset outputs to: imem_we=0, imem_addr=0, imem_din=0, cpu_rstn=0, done=0, err=0, busy=1 and rx_ready=1 from the first cycle after reset.
REQ-040 SHALL, on reset mid-load, discard the partial word; words already written stay in memory.

Structure
REQ-041 SHALL place the state encoding typedef and the byte-per-word constant (4) in the shared core package.
REQ-042 SHALL use one sub-module, byte_packer (2-bit counter plus 32-bit shift register with word_valid output), reused by both LEN and DATA.

Verification
REQ-043 SHALL verify: N=2, then bytes 13 01 01 fe 23 2e 11 00 -> writes (0, fe010113) and (4, 00112e23); done=1 and cpu_rstn=1 one cycle after the second write.
REQ-044 SHALL verify: header 00 00 00 00 -> DONE with no imem_we pulse; cpu_rstn=1 the cycle after the 4th byte.
REQ-045 SHALL verify: N=MAX_WORDS+1 -> err=1, rx_ready=0, cpu_rstn=0; start pulses are ignored.
REQ-046 SHALL verify: N=1 with rx_valid idle for 5 cycles between bytes -> single write (0, word), identical to the gapless case.
REQ-047 SHALL verify: rstn low after 6 DATA bytes of N=3 -> LEN state and zero outputs; a fresh N=1 load then writes address 0.
REQ-048 SHALL verify: start in DONE after N=1 -> cpu_rstn falls on the next cycle and a new N=2 load writes addresses 0 and 4.
